// File: rtl/hud_pkg.sv
// HUD shared types, 7-segment glyph table, BCD helpers and default geometry.
// Latency: none; this package holds declarations and pure functions only.
// Backpressure: not applicable.
package hud_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int DEF_CLK_HZ     = 25_000_000;
    localparam int DEF_START_SECS = 99;
    localparam int DEF_TIME_X     = 110;
    localparam int DEF_SCORE_X    = 598;
    localparam int DEF_Y_TOP      = 445;
    localparam int DEF_WIDTH      = 3;
    localparam int DEF_HEIGHT     = 10;
    localparam int DEF_PITCH      = 20;

    // Segment masks for digits 0..9, bit 6 = a down to bit 0 = g.
    localparam logic [6:0] SEG7_MASK [10] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
    };

    // Non-BCD nibbles render blank.
    function automatic logic [6:0] seg7_mask(input logic [3:0] v);
        return (v <= 4'd9) ? SEG7_MASK[v] : 7'h00;
    endfunction

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Two-digit BCD decrement with borrow; 00 stays 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return v;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Binary 0..99 to two-digit BCD, used for the reload constant.
    function automatic logic [7:0] to_bcd(input int unsigned n);
        return {4'((n / 10) % 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Hit test of one 7-segment digit box at a given origin against the pixel position.
// Latency: combinational.
// Backpressure: not applicable.
module seg7_glyph
    import hud_pkg::*;
#(
    parameter int W = DEF_WIDTH,
    parameter int H = DEF_HEIGHT
) (
    input  logic [9:0] org_x,
    input  logic [9:0] org_y,
    input  logic [3:0] value,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic       hit
);

    localparam logic [9:0] BOX_W = 10'(2 * W + H);
    localparam logic [9:0] BOX_H = 10'(3 * W + 2 * H);
    localparam logic [9:0] W1    = 10'(W);
    localparam logic [9:0] WH    = 10'(W + H);
    localparam logic [9:0] W2H   = 10'(2 * W + H);
    localparam logic [9:0] W2H2  = 10'(2 * W + 2 * H);

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_box;
    logic [6:0] seg;

    // Offsets wrap when left of / above the origin; in_box masks that case out.
    always_comb begin
        dx     = hcount - org_x;
        dy     = vcount - org_y;
        in_box = (hcount >= org_x) && (dx < BOX_W) && (vcount >= org_y) && (dy < BOX_H);
        seg    = 7'h00;
        seg[6] = (dy < W1);                                     // a
        seg[5] = (dx >= WH) && (dy >= W1)  && (dy < WH);        // b
        seg[4] = (dx >= WH) && (dy >= W2H) && (dy < W2H2);      // c
        seg[3] = (dy >= W2H2);                                  // d
        seg[2] = (dx < W1)  && (dy >= W2H) && (dy < W2H2);      // e
        seg[1] = (dx < W1)  && (dy >= W1)  && (dy < WH);        // f
        seg[0] = (dy >= WH) && (dy < W2H);                      // g
        hit    = in_box && |(seg & seg7_mask(value));
    end

endmodule

// File: rtl/hud_controller.sv
// Game HUD: countdown timer, BCD score via 4-phase req/ack, 7-segment overlay mask.
// Latency: digit_pixel 1 cycle after hcount/vcount; score_ack 1 cycle after score_req.
// Backpressure: none; every request is acknowledged, score only moves while running.
module hud_controller
    import hud_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int START_SECS = DEF_START_SECS,
    parameter int TIME_X     = DEF_TIME_X,
    parameter int SCORE_X    = DEF_SCORE_X,
    parameter int Y_TOP      = DEF_Y_TOP,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int PITCH      = DEF_PITCH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       start,
    input  logic       score_req,
    output logic       score_ack,
    output logic       game_over,
    output logic       digit_pixel
);

    localparam int             PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [7:0]     START_BCD  = to_bcd(START_SECS);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    time_q, time_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    time_sh_q, time_sh_d;
    logic [7:0]    score_sh_q, score_sh_d;
    logic          ack_q, ack_d;
    logic          over_q, over_d;
    logic          pix_q, pix_d;
    logic          score_inc;
    logic [7:0]    time_dec;
    logic [3:0]    hit;
    logic [9:0]    glyph_x [4];
    logic [3:0]    glyph_v [4];

    assign glyph_x[0] = 10'(TIME_X);
    assign glyph_x[1] = 10'(TIME_X + PITCH);
    assign glyph_x[2] = 10'(SCORE_X);
    assign glyph_x[3] = 10'(SCORE_X + PITCH);
    assign glyph_v[0] = time_sh_q[7:4];
    assign glyph_v[1] = time_sh_q[3:0];
    assign glyph_v[2] = score_sh_q[7:4];
    assign glyph_v[3] = score_sh_q[3:0];

    for (genvar gi = 0; gi < 4; gi++) begin : g_glyph
        seg7_glyph #(
            .W (WIDTH),
            .H (HEIGHT)
        ) u_glyph (
            .org_x  (glyph_x[gi]),
            .org_y  (10'(Y_TOP)),
            .value  (glyph_v[gi]),
            .hcount (hcount),
            .vcount (vcount),
            .hit    (hit[gi])
        );
    end

    // Next-state: game FSM, prescaler/countdown, score handshake, shadow copy, pixel.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        time_d     = time_q;
        score_d    = score_q;
        time_sh_d  = time_sh_q;
        score_sh_d = score_sh_q;
        over_d     = over_q;
        ack_d      = score_req;
        time_dec   = bcd_dec(time_q);
        // Rising edge of ack is the only point a point is scored.
        score_inc  = score_req && !ack_q && (state_q == RUN);
        if (score_inc)
            score_d = bcd_inc_sat(score_q);

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = RUN;
                    presc_d = '0;
                    time_d  = START_BCD;
                    score_d = 8'h00;
                    over_d  = 1'b0;
                end
            end
            RUN: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    time_d  = time_dec;
                    if (time_dec == 8'h00) begin
                        state_d = OVER;
                        over_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Latch displayed values only at the frame origin so a frame never tears.
        if (hcount == 10'd0 && vcount == 10'd0) begin
            time_sh_d  = time_q;
            score_sh_d = score_q;
        end

        pix_d = |hit;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            time_q     <= START_BCD;
            score_q    <= 8'h00;
            time_sh_q  <= START_BCD;
            score_sh_q <= 8'h00;
            ack_q      <= 1'b0;
            over_q     <= 1'b0;
            pix_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            time_q     <= time_d;
            score_q    <= score_d;
            time_sh_q  <= time_sh_d;
            score_sh_q <= score_sh_d;
            ack_q      <= ack_d;
            over_q     <= over_d;
            pix_q      <= pix_d;
        end
    end

    assign score_ack   = ack_q;
    assign game_over   = over_q;
    assign digit_pixel = pix_q;

endmodule

// File: tb/tb_hud_controller.sv
// Directed bench for hud_controller: timer countdown, score handshake, anti-tearing, rendering.
// Latency: pixel expectations are queued on drive and popped one cycle later.
// Backpressure: not applicable.
module tb_hud_controller;

    localparam int CLK_HZ     = 40;
    localparam int START_SECS = 10;
    localparam int TIME_X     = 110;
    localparam int SCORE_X    = 598;
    localparam int Y_TOP      = 445;
    localparam int WIDTH      = 3;
    localparam int HEIGHT     = 10;
    localparam int PITCH      = 20;

    // Sample point inside each segment a..g, relative to the digit origin.
    localparam int OFFX [7] = '{8, 14, 14, 8, 1, 1, 8};
    localparam int OFFY [7] = '{1, 8, 20, 27, 20, 8, 14};
    // Lit segments per digit, bit 6 = a .. bit 0 = g.
    localparam logic [6:0] MASK [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       start = 1'b0;
    logic       score_req = 1'b0;
    logic       score_ack;
    logic       game_over;
    logic       digit_pixel;

    int   passes = 0;
    int   fails = 0;
    int   checks = 0;
    int   ncyc = 0;
    int   tl = 0;
    logic exp_q [$];

    hud_controller #(
        .CLK_HZ     (CLK_HZ),
        .START_SECS (START_SECS),
        .TIME_X     (TIME_X),
        .SCORE_X    (SCORE_X),
        .Y_TOP      (Y_TOP),
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .PITCH      (PITCH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .start       (start),
        .score_req   (score_req),
        .score_ack   (score_ack),
        .game_over   (game_over),
        .digit_pixel (digit_pixel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic probe(input int x, input int y, input logic e, input string tag);
        hcount = 10'(x);
        vcount = 10'(y);
        exp_q.push_back(e);
        tick();
        chk(tag, {31'd0, digit_pixel}, {31'd0, exp_q.pop_front()});
    endtask

    // Live time value sampled by a latch on edge m after the start edge.
    function automatic int exp_time(input int m);
        int k;
        k = (m - 1) / CLK_HZ;
        return (k >= START_SECS) ? 0 : START_SECS - k;
    endfunction

    task automatic check_frame(input int t, input int s, input bit latch, input string tag);
        int dig [4];
        int ox [4];
        dig = '{t / 10, t % 10, s / 10, s % 10};
        ox  = '{TIME_X, TIME_X + PITCH, SCORE_X, SCORE_X + PITCH};
        if (latch)
            probe(0, 0, 1'b0, {tag, ".latch"});
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 7; j++)
                probe(ox[i] + OFFX[j], Y_TOP + OFFY[j], MASK[dig[i]][6-j],
                      $sformatf("%s.d%0d.s%0d", tag, i, j));
        probe(SCORE_X + 16, Y_TOP + 1, 1'b0, {tag, ".out_right"});
        probe(TIME_X + 8, Y_TOP - 1, 1'b0, {tag, ".out_above"});
    endtask

    task automatic score_pulse(input string tag);
        score_req = 1'b1;
        tick();
        chk({tag, ".ack_hi"}, {31'd0, score_ack}, 32'd1);
        score_req = 1'b0;
        tick();
        chk({tag, ".ack_lo"}, {31'd0, score_ack}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst.game_over", {31'd0, game_over}, 32'd0);
        chk("rst.ack", {31'd0, score_ack}, 32'd0);
        chk("rst.pixel", {31'd0, digit_pixel}, 32'd0);
        rst_n = 1'b1;
        check_frame(START_SECS, 0, 1'b1, "rst_frame");
        score_pulse("idle_ack");

        // Start, then a 5-cycle request in RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        ncyc = 0;
        chk("run.game_over", {31'd0, game_over}, 32'd0);
        score_req = 1'b1;
        chk("run.ack_pre", {31'd0, score_ack}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("run.ack_hold%0d", k), {31'd0, score_ack}, 32'd1);
        end
        score_req = 1'b0;
        tick();
        chk("run.ack_fall", {31'd0, score_ack}, 32'd0);
        check_frame(exp_time(ncyc + 1), 1, 1'b1, "run_a");
        while (ncyc < 44) tick();
        check_frame(exp_time(ncyc + 1), 1, 1'b1, "run_b");

        // Mid-frame increment is hidden until the next frame origin
        score_pulse("tear_inc");
        check_frame(9, 1, 1'b0, "tear_hold");
        tl = exp_time(ncyc + 1);
        check_frame(tl, 2, 1'b1, "tear_new");
        probe(TIME_X + PITCH + 1, Y_TOP + WIDTH + HEIGHT + 1, MASK[tl % 10][0], "seg_g_lit");

        // start ignored while running
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run.start_ignored", {31'd0, game_over}, 32'd0);

        // Ack rising edge on the final tick
        while (ncyc < 399) tick();
        chk("final.pre_over", {31'd0, game_over}, 32'd0);
        score_req = 1'b1;
        tick();
        chk("final.game_over", {31'd0, game_over}, 32'd1);
        chk("final.ack", {31'd0, score_ack}, 32'd1);
        score_req = 1'b0;
        tick();
        chk("final.ack_fall", {31'd0, score_ack}, 32'd0);
        check_frame(0, 3, 1'b1, "over_frame");
        probe(TIME_X + PITCH + 1, Y_TOP + WIDTH + HEIGHT + 1, 1'b0, "seg_g_zero");
        score_pulse("over_ack");
        check_frame(0, 3, 1'b1, "over_hold");
        chk("over.game_over", {31'd0, game_over}, 32'd1);

        // Restart from OVER, then saturate the score
        start = 1'b1;
        tick();
        start = 1'b0;
        ncyc = 0;
        chk("restart.game_over", {31'd0, game_over}, 32'd0);
        check_frame(exp_time(ncyc + 1), 0, 1'b1, "restart");
        for (int k = 0; k < 99; k++) score_pulse("inc");
        score_pulse("sat1");
        score_pulse("sat2");
        check_frame(exp_time(ncyc + 1), 99, 1'b1, "sat");

        // Asynchronous reset mid-run
        probe(SCORE_X + 8, Y_TOP + 1, 1'b1, "pre_rst_lit");
        score_req = 1'b1;
        tick();
        chk("pre_rst.ack", {31'd0, score_ack}, 32'd1);
        chk("pre_rst.pixel", {31'd0, digit_pixel}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.game_over", {31'd0, game_over}, 32'd0);
        chk("async_rst.ack", {31'd0, score_ack}, 32'd0);
        chk("async_rst.pixel", {31'd0, digit_pixel}, 32'd0);
        score_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_frame(START_SECS, 0, 1'b1, "post_rst");
        repeat (45) tick();
        chk("idle.game_over", {31'd0, game_over}, 32'd0);
        check_frame(START_SECS, 0, 1'b1, "idle_hold");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
